vctr_frame_ctrl: RTL

Command-frame controller between the UART receiver and the vctr output register bank. It parses the byte stream into frames: sync 0xA5, then address, then data. It writes the data into one of NREG 8-bit vector registers, drops malformed or stalled frames, and counts errors. It owns all writes to the vector bank; the UART receiver only delivers bytes.

---
 rtl/vctr_frame_ctrl.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/vctr_frame_ctrl.sv
// vctr_frame_ctrl: command-frame parser between the UART receiver and the
// vector output register bank. It parses sync/address/data byte frames,
// writes one 8-bit register per good frame, and discards and counts
// malformed or stalled frames.
// Optional build macro FRAME_CSUM_EN: adds a trailing checksum byte
// (addr ^ data) to every frame and checks it before the commit.
module vctr_frame_ctrl #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter int         NREG      = 4,
    parameter int         ADDR_W    = 2,
    parameter int         TIMEOUT   = 48000,
    parameter int         TO_W      = 16
) (
    input  logic                clock,
    input  logic                rst,
    input  logic                rx_valid,
    input  logic [7:0]          rx_byte,
    output logic [8*NREG-1:0]   vctr_out,
    output logic                reg_we,
    output logic [ADDR_W-1:0]   reg_addr,
    output logic                frame_err,
    output logic [7:0]          err_cnt,
    output logic                busy
);

`ifdef FRAME_CSUM_EN
    typedef enum logic [1:0] {IDLE, GET_ADDR, GET_DATA, GET_CSUM} state_t;
`else
    typedef enum logic [1:0] {IDLE, GET_ADDR, GET_DATA} state_t;
`endif

    state_t              state_q, state_d;
    logic [TO_W-1:0]     cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                drop_q, drop_d;
    logic [8*NREG-1:0]   vctr_q, vctr_d;
    logic                reg_we_q, reg_we_d;
    logic [ADDR_W-1:0]   reg_addr_q, reg_addr_d;
    logic                frame_err_q, frame_err_d;
    logic [7:0]          err_cnt_q, err_cnt_d;
`ifdef FRAME_CSUM_EN
    logic [7:0]          data_q, data_d;
    logic [7:0]          csum_exp;
`endif

    // Per-cycle frame outcome decided by the parser below.
    logic                commit;
    logic                discard;
    logic [7:0]          wdata;

`ifdef FRAME_CSUM_EN
    // The drop flag covers nonzero upper address bits, so only the latched
    // index bits can take part in a checksum that leads to a commit.
    assign csum_exp = {{(8-ADDR_W){1'b0}}, addr_q} ^ data_q;
`endif

    // Next-state, frame parsing, timeout and output-register update.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one
        // unassigned, which would infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        drop_d      = drop_q;
        vctr_d      = vctr_q;
        reg_we_d    = 1'b0;
        reg_addr_d  = reg_addr_q;
        frame_err_d = 1'b0;
        err_cnt_d   = err_cnt_q;
        commit      = 1'b0;
        discard     = 1'b0;
        wdata       = 8'h00;
`ifdef FRAME_CSUM_EN
        data_d      = data_q;
`endif

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (rx_valid && rx_byte == SYNC_BYTE) begin
                    state_d = GET_ADDR;
                end
            end
            GET_ADDR: begin
                // A sync byte here is just another address value.
                if (rx_valid) begin
                    addr_d  = rx_byte[ADDR_W-1:0];
                    drop_d  = |rx_byte[7:ADDR_W];
                    state_d = GET_DATA;
                end
            end
            GET_DATA: begin
                if (rx_valid) begin
`ifdef FRAME_CSUM_EN
                    data_d  = rx_byte;
                    state_d = GET_CSUM;
`else
                    wdata   = rx_byte;
                    commit  = !drop_q;
                    discard = drop_q;
                    state_d = IDLE;
`endif
                end
            end
`ifdef FRAME_CSUM_EN
            GET_CSUM: begin
                if (rx_valid) begin
                    wdata   = data_q;
                    commit  = !drop_q && (rx_byte == csum_exp);
                    discard = !commit;
                    state_d = IDLE;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase

        // Inter-byte stall detection; a byte arriving in the expiry cycle wins.
        if (state_q != IDLE) begin
            if (rx_valid) begin
                cnt_d = '0;
            end else if (cnt_q == TO_W'(TIMEOUT - 1)) begin
                cnt_d   = '0;
                state_d = IDLE;
                discard = 1'b1;
            end else begin
                cnt_d = cnt_q + TO_W'(1);
            end
        end

        if (commit) begin
            vctr_d[8*addr_q +: 8] = wdata;
            reg_we_d              = 1'b1;
            reg_addr_d            = addr_q;
        end

        if (discard) begin
            frame_err_d = 1'b1;
            if (err_cnt_q != 8'hFF) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            // NOTE: the register bank is a handful of flops, not a RAM, and
            // must read back as zero after reset, so it is reset too.
            state_q     <= IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            drop_q      <= 1'b0;
            vctr_q      <= '0;
            reg_we_q    <= 1'b0;
            reg_addr_q  <= '0;
            frame_err_q <= 1'b0;
            err_cnt_q   <= 8'h00;
`ifdef FRAME_CSUM_EN
            data_q      <= 8'h00;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            drop_q      <= drop_d;
            vctr_q      <= vctr_d;
            reg_we_q    <= reg_we_d;
            reg_addr_q  <= reg_addr_d;
            frame_err_q <= frame_err_d;
            err_cnt_q   <= err_cnt_d;
`ifdef FRAME_CSUM_EN
            data_q      <= data_d;
`endif
        end
    end

    assign vctr_out  = vctr_q;
    assign reg_we    = reg_we_q;
    assign reg_addr  = reg_addr_q;
    assign frame_err = frame_err_q;
    assign err_cnt   = err_cnt_q;
    assign busy      = (state_q != IDLE);

endmodule
